audio_pcm_unpacker: RTL and testbench

- Downstream consumer of the 4 KiB audio byte FIFO (1-cycle registered read, `empty` flag).
- Paces sample fetches with a rate phase accumulator driven by the base sample tick.
- Pulls 1/2/4 bytes per sample frame according to mode and assembles signed 16-bit left/right samples.
- Presents the samples to the audio mixer/DAC stage with a one-cycle valid strobe.

---
 rtl/audio_pcm_unpacker_if.sv | 28 ++
 rtl/audio_pcm_unpacker.sv | 145 ++++++++++++++
 tb/tb_audio_pcm_unpacker.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/audio_pcm_unpacker_if.sv
// Bundles the FIFO read port and the sample output bus of the PCM unpacker.
//   fifo_rddata  : byte from the audio FIFO, valid the cycle after fifo_rd_en
//   fifo_empty   : FIFO empty flag
//   fifo_rd_en   : FIFO read request
//   left_sample  : signed 16-bit left sample
//   right_sample : signed 16-bit right sample
//   sample_valid : one-cycle strobe, new frame on the sample outputs
//   underrun     : one-cycle strobe, fetch was due but the FIFO was empty
// master = the unpacker, slave = the FIFO / mixer side.
interface audio_pcm_unpacker_if;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rddata;
    logic        fifo_empty;
    logic [15:0] left_sample;
    logic [15:0] right_sample;
    logic        sample_valid;
    logic        underrun;

    modport master (
        input  fifo_rddata, fifo_empty,
        output fifo_rd_en, left_sample, right_sample, sample_valid, underrun
    );

    modport slave (
        output fifo_rddata, fifo_empty,
        input  fifo_rd_en, left_sample, right_sample, sample_valid, underrun
    );
endinterface

// File: rtl/audio_pcm_unpacker.sv
// Pulls PCM bytes out of the audio FIFO at a rate set by a phase accumulator
// and assembles them into signed 16-bit left/right samples.
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : playback enable; low clears the pacing and abandons a frame
//   sample_tick : one-cycle base-rate strobe
//   rate        : playback rate, 128 = full rate, larger values clamp to 128
//   mode_16bit  : 1 = 16-bit samples, 0 = 8-bit
//   mode_stereo : 1 = stereo, 0 = mono
//   bus         : FIFO read port and sample output bus (master side)
module audio_pcm_unpacker #(
    parameter int RATE_W = 8,
    parameter int ACC_W  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              sample_tick,
    input  logic [RATE_W-1:0] rate,
    input  logic              mode_16bit,
    input  logic              mode_stereo,
    audio_pcm_unpacker_if.master bus
);
    typedef enum logic [1:0] {IDLE, RD, CAP, DONE} state_t;

    localparam logic [RATE_W-1:0] RATE_MAX = RATE_W'(1 << ACC_W);

    state_t          state, state_d;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]  sum;
    logic [RATE_W-1:0] rate_c;
    logic            carry, pending, fetch_req;
    logic [1:0]      k, nb_m1;
    logic            m16, mst;
    logic [3:0][7:0] byte_q, fb;
    logic [15:0]     left_q, right_q, left_d, right_d;
    logic            rd_en, und, valid, start, cap;

    assign rate_c = (rate > RATE_MAX) ? RATE_MAX : rate;
    assign sum    = (ACC_W+1)'(acc) + (ACC_W+1)'(rate_c);
    assign carry  = enable & sample_tick & sum[ACC_W];
    // A carry in the current cycle starts a frame directly from IDLE, so the
    // first read issues the cycle after the tick.
    assign fetch_req = enable & (pending | carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            pending <= 1'b0;
        end else if (!enable) begin
            acc     <= '0;
            pending <= 1'b0;
        end else begin
            if (sample_tick)
                acc <= sum[ACC_W-1:0];
            // Consumed (started or underrun) in IDLE; extra carries are absorbed.
            if (state == IDLE && fetch_req)
                pending <= 1'b0;
            else if (carry)
                pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        rd_en   = 1'b0;
        und     = 1'b0;
        start   = 1'b0;
        cap     = 1'b0;
        valid   = (state == DONE);
        case (state)
            IDLE: if (fetch_req) begin
                if (bus.fifo_empty) und = 1'b1;
                else begin
                    start   = 1'b1;
                    state_d = RD;
                end
            end
            RD: if (!bus.fifo_empty) begin
                rd_en   = 1'b1;
                state_d = CAP;
            end
            CAP: begin
                cap     = 1'b1;
                state_d = (k == nb_m1) ? DONE : RD;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d = IDLE;
            rd_en   = 1'b0;
            und     = 1'b0;
            start   = 1'b0;
            cap     = 1'b0;
        end
    end

    // Frame bytes as they will be once the byte arriving in CAP is stored,
    // so the outputs are already updated during DONE.
    always_comb begin
        fb    = byte_q;
        fb[k] = bus.fifo_rddata;
        left_d = m16 ? {fb[1], fb[0]} : {fb[0], 8'h00};
        if (!mst)     right_d = left_d;
        else if (m16) right_d = {fb[3], fb[2]};
        else          right_d = {fb[1], 8'h00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k       <= '0;
            nb_m1   <= '0;
            m16     <= 1'b0;
            mst     <= 1'b0;
            byte_q  <= '0;
            left_q  <= '0;
            right_q <= '0;
        end else if (start) begin
            m16   <= mode_16bit;
            mst   <= mode_stereo;
            // bytes per frame minus one: 8m=0, 8s=1, 16m=1, 16s=3
            nb_m1 <= {mode_16bit & mode_stereo, mode_16bit | mode_stereo};
            k     <= '0;
        end else if (cap) begin
            byte_q[k] <= bus.fifo_rddata;
            if (k == nb_m1) begin
                left_q  <= left_d;
                right_q <= right_d;
            end else begin
                k <= k + 2'd1;
            end
        end
    end

    assign bus.fifo_rd_en   = rd_en;
    assign bus.underrun     = und;
    assign bus.sample_valid = valid;
    assign bus.left_sample  = left_q;
    assign bus.right_sample = right_q;
endmodule

// File: tb/tb_audio_pcm_unpacker.sv
// Directed bench for audio_pcm_unpacker with a behavioural registered-read FIFO.
module tb_audio_pcm_unpacker;
    logic       clk = 1'b0;
    logic       rst_n, enable, sample_tick, mode_16bit, mode_stereo;
    logic [7:0] rate;

    audio_pcm_unpacker_if bus ();

    audio_pcm_unpacker #(.RATE_W(8), .ACC_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample_tick(sample_tick),
        .rate(rate), .mode_16bit(mode_16bit), .mode_stereo(mode_stereo),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // FIFO model: 1-cycle registered read
    logic [7:0] fmem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign bus.fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_rddata <= fmem[rd_ptr[5:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // event monitor
    int n_valid = 0, n_rd = 0, n_und = 0, n_bad = 0;
    int valid_cyc = 0, und_cyc = 0;
    always @(negedge clk) begin
        if (bus.sample_valid) begin
            n_valid++;
            valid_cyc = cyc;
        end
        if (bus.fifo_rd_en) begin
            n_rd++;
            if (bus.fifo_empty) n_bad++;
        end
        if (bus.underrun) begin
            n_und++;
            und_cyc = cyc;
        end
    end

    int n_chk = 0, n_pass = 0;
    int b_v, b_rd, b_u, tick_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic next(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        fmem[wr_ptr[5:0]] = b;
        wr_ptr++;
    endtask

    task automatic snap();
        b_v  = n_valid;
        b_rd = n_rd;
        b_u  = n_und;
    endtask

    task automatic do_tick();
        sample_tick = 1'b1;
        tick_cyc    = cyc;
        next();
        sample_tick = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; sample_tick = 1'b0;
        rate = 8'd0; mode_16bit = 1'b0; mode_stereo = 1'b0;
        next(3);
        check("rst_left",  32'(bus.left_sample), 32'h0);
        check("rst_right", 32'(bus.right_sample), 32'h0);
        check("rst_valid", 32'(bus.sample_valid), 32'h0);
        check("rst_rden",  32'(bus.fifo_rd_en), 32'h0);
        rst_n = 1'b1;
        next(2);

        // 8-bit mono, full rate
        enable = 1'b1; rate = 8'd128;
        push(8'h12); push(8'h80);
        snap();
        do_tick(); next(5);
        check("m8_f1_cnt",   32'(n_valid - b_v), 32'd1);
        check("m8_f1_left",  32'(bus.left_sample), 32'h1200);
        check("m8_f1_right", 32'(bus.right_sample), 32'h1200);
        check("m8_f1_lat",   32'(valid_cyc - tick_cyc), 32'd3);
        do_tick(); next(5);
        check("m8_f2_cnt",   32'(n_valid - b_v), 32'd2);
        check("m8_f2_left",  32'(bus.left_sample), 32'h8000);
        check("m8_f2_right", 32'(bus.right_sample), 32'h8000);
        check("m8_f2_lat",   32'(valid_cyc - tick_cyc), 32'd3);

        // 16-bit stereo
        mode_16bit = 1'b1; mode_stereo = 1'b1;
        push(8'h34); push(8'h12); push(8'h78); push(8'h56);
        snap();
        do_tick(); next(12);
        check("s16_cnt",   32'(n_valid - b_v), 32'd1);
        check("s16_left",  32'(bus.left_sample), 32'h1234);
        check("s16_right", 32'(bus.right_sample), 32'h5678);
        check("s16_lat",   32'(valid_cyc - tick_cyc), 32'd9);
        check("s16_rd",    32'(n_rd - b_rd), 32'd4);

        // half rate, 8-bit stereo: 8 ticks -> 4 frames
        mode_16bit = 1'b0; mode_stereo = 1'b1; rate = 8'd64;
        for (int i = 1; i <= 8; i++) push(8'(i));
        snap();
        for (int i = 0; i < 8; i++) begin
            do_tick(); next(7);
        end
        check("half_frames", 32'(n_valid - b_v), 32'd4);
        check("half_rd",     32'(n_rd - b_rd), 32'd8);
        check("half_left",   32'(bus.left_sample), 32'h0700);
        check("half_right",  32'(bus.right_sample), 32'h0800);

        // underrun: FIFO empty at carry
        mode_stereo = 1'b0; rate = 8'd128;
        snap();
        do_tick(); next(5);
        check("und_cnt",   32'(n_und - b_u), 32'd1);
        check("und_cyc",   32'(und_cyc - tick_cyc), 32'd0);
        check("und_rd",    32'(n_rd - b_rd), 32'd0);
        check("und_valid", 32'(n_valid - b_v), 32'd0);
        check("und_left",  32'(bus.left_sample), 32'h0700);

        // rate 0 never fetches
        push(8'hCD);
        rate = 8'd0;
        snap();
        for (int i = 0; i < 4; i++) begin
            do_tick(); next(3);
        end
        check("r0_rd",  32'(n_rd - b_rd), 32'd0);
        check("r0_und", 32'(n_und - b_u), 32'd0);

        // stall mid-frame: 16-bit mono with only the low byte present
        rate = 8'd200; mode_16bit = 1'b1; mode_stereo = 1'b0;
        snap();
        do_tick(); next(20);
        check("stall_valid", 32'(n_valid - b_v), 32'd0);
        check("stall_rd",    32'(n_rd - b_rd), 32'd1);
        push(8'hAB);
        next(5);
        check("stall_done",  32'(n_valid - b_v), 32'd1);
        check("stall_left",  32'(bus.left_sample), 32'hABCD);
        check("stall_right", 32'(bus.right_sample), 32'hABCD);

        // enable dropped mid-frame (16-bit stereo), then a 16-bit mono frame
        mode_stereo = 1'b1; rate = 8'd128;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        snap();
        do_tick(); next(2);
        enable = 1'b0;
        next(10);
        check("abort_valid", 32'(n_valid - b_v), 32'd0);
        check("abort_rd",    32'(n_rd - b_rd), 32'd1);
        check("abort_left",  32'(bus.left_sample), 32'hABCD);
        enable = 1'b1; mode_stereo = 1'b0;
        next(2);
        do_tick(); next(8);
        check("reen_valid", 32'(n_valid - b_v), 32'd1);
        check("reen_left",  32'(bus.left_sample), 32'h3322);
        check("reen_right", 32'(bus.right_sample), 32'h3322);
        check("no_rd_empty", 32'(n_bad), 32'd0);

        // asynchronous reset with nonzero outputs
        rst_n = 1'b0;
        #1;
        check("arst_left",  32'(bus.left_sample), 32'h0);
        check("arst_right", 32'(bus.right_sample), 32'h0);
        next(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
